// File: rtl/scan_chain_master.sv
// scan_chain_master: shifts {data, address} out onto a TAP daisy chain
// (TCK/TMS/TDI), then issues one update pulse. Every TCK half-period waits
// for the returned RTCK to follow, with a timeout, and TDO is captured into
// a parallel result word.
//
// Handshake: start is a one-cycle request, accepted only while busy=0. done
// is a one-cycle pulse that marks a completed frame. It arrives in the same
// cycle that o_pins takes the new value.
module scan_chain_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  continuous,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] i_pins,
   input  logic                  rtck,
   input  logic                  tdo,
   output logic                  tck,
   output logic                  tms,
   output logic                  tdi,
   output logic [DATA_WIDTH-1:0] o_pins,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [2:0]            dbg_state
);

   localparam int FRAME_LEN = ADDR_WIDTH + DATA_WIDTH;
   localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int PH_W      = $clog2(CLK_DIV + 1);
   localparam int WT_W      = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOW      = 3'd1,
      S_HIGH     = 3'd2,
      S_UPD_LOW  = 3'd3,
      S_UPD_HIGH = 3'd4,
      S_ABORT    = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [FRAME_LEN-1:0]   shift_q, shift_d;
   logic [FRAME_LEN-1:0]   cap_q, cap_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [PH_W-1:0]        phase_q, phase_d;
   logic [WT_W-1:0]        wait_q, wait_d;
   logic                   tck_q, tck_d;
   logic                   tms_q, tms_d;
   logic                   tdi_q, tdi_d;
   logic [DATA_WIDTH-1:0]  o_pins_q, o_pins_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   timeout_q, timeout_d;
   logic                   rtck_meta_q, rtck_meta_d, rtck_s_q, rtck_s_d;
   logic                   tdo_meta_q, tdo_meta_d, tdo_s_q, tdo_s_d;

   logic                   tck_lvl;
   logic                   paced;
   logic                   rtck_match;
   logic                   half_done;
   logic                   launch;

   // Next-state, counters and registered pin values
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cap_d       = cap_q;
      idx_d       = idx_q;
      phase_d     = phase_q;
      wait_d      = wait_q;
      o_pins_d    = o_pins_q;
      timeout_d   = timeout_q;
      done_d      = 1'b0;
      launch      = 1'b0;
      rtck_meta_d = rtck;
      rtck_s_d    = rtck_meta_q;
      tdo_meta_d  = tdo;
      tdo_s_d     = tdo_meta_q;

      tck_lvl    = (state_q == S_HIGH) || (state_q == S_UPD_HIGH);
      paced      = (state_q == S_LOW) || (state_q == S_HIGH) ||
                   (state_q == S_UPD_LOW) || (state_q == S_UPD_HIGH);
      rtck_match = (rtck_s_q == tck_lvl);
      // The phase counter only advances while RTCK agrees with TCK. So a
      // half-period is CLK_DIV cycles once the chain has caught up.
      half_done  = rtck_match && (phase_q >= PH_W'(CLK_DIV - 1));

      case (state_q)
         S_IDLE: begin
            if (start) launch = 1'b1;
         end
         S_LOW: begin
            if (half_done) state_d = S_HIGH;
         end
         S_HIGH: begin
            if (half_done) begin
               cap_d[idx_q] = tdo_s_q;
               if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                  state_d = S_UPD_LOW;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_LOW;
               end
            end
         end
         S_UPD_LOW: begin
            if (half_done) state_d = S_UPD_HIGH;
         end
         S_UPD_HIGH: begin
            if (half_done) begin
               o_pins_d = cap_q[FRAME_LEN-1:ADDR_WIDTH];
               done_d   = 1'b1;
               if (continuous) launch = 1'b1;
               else            state_d = S_IDLE;
            end
         end
         S_ABORT: begin
            if (phase_q >= PH_W'(CLK_DIV - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A chain that never echoes TCK back aborts the frame.
      if (paced && !rtck_match) begin
         if (wait_q == WT_W'(TIMEOUT - 1)) begin
            state_d   = S_ABORT;
            timeout_d = 1'b1;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end

      if ((paced && rtck_match) || (state_q == S_ABORT)) begin
         if (phase_q != PH_W'(CLK_DIV)) phase_d = phase_q + 1'b1;
      end

      if (launch) begin
         shift_d   = {i_pins, addr};
         idx_d     = '0;
         timeout_d = 1'b0;
         state_d   = S_LOW;
      end

      if (state_d != state_q) begin
         phase_d = '0;
         wait_d  = '0;
      end

      // Pins are registered from the next state so they change at state entry
      busy_d = (state_d != S_IDLE);
      tck_d  = (state_d == S_HIGH) || (state_d == S_UPD_HIGH);
      tms_d  = (state_d == S_UPD_LOW) || (state_d == S_UPD_HIGH) ||
               (state_d == S_ABORT);
      tdi_d  = ((state_d == S_LOW) || (state_d == S_HIGH)) ? shift_d[idx_d] : 1'b0;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         cap_q       <= '0;
         idx_q       <= '0;
         phase_q     <= '0;
         wait_q      <= '0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b0;
         tdi_q       <= 1'b0;
         o_pins_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         rtck_meta_q <= 1'b0;
         rtck_s_q    <= 1'b0;
         tdo_meta_q  <= 1'b0;
         tdo_s_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cap_q       <= cap_d;
         idx_q       <= idx_d;
         phase_q     <= phase_d;
         wait_q      <= wait_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         o_pins_q    <= o_pins_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         rtck_meta_q <= rtck_meta_d;
         rtck_s_q    <= rtck_s_d;
         tdo_meta_q  <= tdo_meta_d;
         tdo_s_q     <= tdo_s_d;
      end
   end

   assign tck       = tck_q;
   assign tms       = tms_q;
   assign tdi       = tdi_q;
   assign o_pins    = o_pins_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_scan_chain_master.sv
// Bench for scan_chain_master. A chain model echoes TCK back as RTCK after
// 3 clk, or with no delay, or never, or as a free-running toggle. On each
// TCK rise the model returns the inverse of TDI on TDO.
module tb_scan_chain_master;

   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int CLK_DIV = 2;
   localparam int TMO     = 10;

   logic          clk = 1'b0;
   logic          reset, start, continuous, rtck, tdo;
   logic [AW-1:0] addr;
   logic [DW-1:0] i_pins, o_pins;
   logic          tck, tms, tdi, busy, done, timeout;
   logic [2:0]    dbg_state;

   int errors = 0;
   int checks = 0;

   // Clock and DUT
   always #5 clk = ~clk;

   scan_chain_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .addr(addr), .i_pins(i_pins), .rtck(rtck), .tdo(tdo),
      .tck(tck), .tms(tms), .tdi(tdi), .o_pins(o_pins),
      .busy(busy), .done(done), .timeout(timeout), .dbg_state(dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Chain model: 0 = 3-clk RTCK delay, 1 = zero delay, 2 = stuck low, 3 = toggling
   int         rtck_mode = 3;
   logic [2:0] dly_q = 3'b000;
   logic       tog_q = 1'b0;
   logic       chain_q = 1'b0;

   always @(posedge clk) begin
      dly_q <= {dly_q[1:0], tck};
      tog_q <= ~tog_q;
   end

   always_comb begin
      case (rtck_mode)
         0:       rtck = dly_q[2];
         1:       rtck = tck;
         2:       rtck = 1'b0;
         default: rtck = tog_q;
      endcase
   end

   assign tdo = ~chain_q;

   // Scoreboard and pulse monitor
   logic [0:0] exp_q[$];
   logic [0:0] exp_bit;
   bit         mon_en = 1'b0;
   logic       prev_tck = 1'b0;
   int         shift_cnt = 0;
   int         upd_cnt = 0;
   int         done_cnt = 0;
   int         hi_run = 0;
   int         hi_min = 1000;
   int         hi_max = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (tck && !prev_tck) begin
            if (!tms) begin
               shift_cnt++;
               chain_q = tdi;
               check("sb_nonempty", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  exp_bit = exp_q.pop_front();
                  check("tdi_bit", tdi, exp_bit);
               end
            end else begin
               upd_cnt++;
               check("upd_tdi", tdi, 0);
            end
         end
         if (tck) begin
            hi_run++;
         end else if (prev_tck) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
         end
         if (done) done_cnt++;
      end
      prev_tck = tck;
   end

   // Driver tasks
   task automatic push_word(input logic [15:0] w);
      for (int i = 0; i < 16; i++) exp_q.push_back(w[i]);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int cyc);
      cyc = 0;
      while (!done && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tck"}, tck, 0);
      check({tag, "_tms"}, tms, 0);
      check({tag, "_tdi"}, tdi, 0);
      check({tag, "_o_pins"}, o_pins, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_timeout"}, timeout, 0);
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [15:0]   exp_tdi;
      logic [DW-1:0] exp_o;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int cyc, n, base_s, base_u, base_d;

      vecs[0] = '{8'h01, 8'hA5, 16'hA501, 8'h5A};
      vecs[1] = '{8'hFF, 8'h00, 16'h00FF, 8'hFF};
      vecs[2] = '{8'h3C, 8'h81, 16'h813C, 8'h7E};
      vecs[3] = '{8'h80, 8'h5A, 16'h5A80, 8'hA5};

      reset = 1'b1; start = 1'b0; continuous = 1'b0;
      addr = '0; i_pins = '0;

      // Reset held 3 cycles with RTCK toggling
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      rtck_mode = 0;
      mon_en = 1'b1;
      repeat (5) @(negedge clk);

      // Single frames over the 3-clk delayed chain
      for (int v = 0; v < 4; v++) begin
         base_s = shift_cnt; base_u = upd_cnt; base_d = done_cnt;
         push_word(vecs[v].exp_tdi);
         addr = vecs[v].addr;
         i_pins = vecs[v].din;
         pulse_start();
         wait_done(3000, cyc);
         repeat (3) @(negedge clk);
         check("vec_shift_pulses", shift_cnt - base_s, 16);
         check("vec_upd_pulses", upd_cnt - base_u, 1);
         check("vec_done_pulses", done_cnt - base_d, 1);
         check("vec_o_pins", o_pins, vecs[v].exp_o);
         check("vec_sb_empty", exp_q.size(), 0);
         check("vec_idle", busy, 0);
      end

      // Zero-delay RTCK: fixed half-periods and a fixed frame length
      rtck_mode = 1;
      repeat (4) @(negedge clk);
      hi_min = 1000; hi_max = 0;
      push_word(16'hC30F);
      addr = 8'h0F; i_pins = 8'hC3;
      pulse_start();
      wait_done(3000, cyc);
      check("zd_frame_cycles", cyc, 134);
      repeat (3) @(negedge clk);
      check("zd_high_min", hi_min, CLK_DIV + 2);
      check("zd_high_max", hi_max, CLK_DIV + 2);
      check("zd_o_pins", o_pins, 8'h3C);

      // Stuck RTCK: timeout, abort pulse, no restart even in continuous mode
      rtck_mode = 2;
      continuous = 1'b1;
      base_d = done_cnt;
      push_word(16'h6655);
      addr = 8'h55; i_pins = 8'h66;
      pulse_start();
      n = 0;
      while (!tck && n < 20) begin @(negedge clk); n++; end
      check("stuck_tck_rose", tck, 1);
      n = 0;
      while (!timeout && n < 30) begin @(negedge clk); n++; end
      check("stuck_timeout_set", timeout, 1);
      check("stuck_timeout_latency", n <= CLK_DIV + 2 + TMO, 1);
      check("abort_tck", tck, 0);
      check("abort_tms", tms, 1);
      check("abort_tdi", tdi, 0);
      n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      check("abort_busy_clear", busy, 0);
      check("abort_tms_clear", tms, 0);
      repeat (10) @(negedge clk);
      check("abort_no_restart", busy, 0);
      check("abort_timeout_sticky", timeout, 1);
      check("abort_o_pins_kept", o_pins, 8'h3C);
      check("abort_no_done", done_cnt - base_d, 0);
      exp_q.delete();
      continuous = 1'b0;
      rtck_mode = 0;
      repeat (8) @(negedge clk);

      // Continuous mode, address changed during the first frame
      base_s = shift_cnt; base_u = upd_cnt; base_d = done_cnt;
      push_word(16'h2211);
      push_word(16'h4433);
      continuous = 1'b1;
      addr = 8'h11; i_pins = 8'h22;
      pulse_start();
      n = 0;
      while (shift_cnt < base_s + 4 && n < 500) begin @(negedge clk); n++; end
      addr = 8'h33; i_pins = 8'h44;
      wait_done(3000, cyc);
      check("cont_busy_between", busy, 1);
      check("cont_o_pins_1", o_pins, 8'hDD);
      check("cont_timeout_cleared", timeout, 0);
      continuous = 1'b0;
      @(negedge clk);
      wait_done(3000, cyc);
      check("cont_busy_end", busy, 0);
      check("cont_o_pins_2", o_pins, 8'hBB);
      repeat (20) @(negedge clk);
      check("cont_stays_idle", busy, 0);
      check("cont_done_pulses", done_cnt - base_d, 2);
      check("cont_shift_pulses", shift_cnt - base_s, 32);
      check("cont_upd_pulses", upd_cnt - base_u, 2);
      check("cont_sb_empty", exp_q.size(), 0);

      // Reset during shift bit 7, then a clean frame
      base_s = shift_cnt;
      push_word(16'h3E9C);
      addr = 8'h9C; i_pins = 8'h3E;
      pulse_start();
      n = 0;
      while (shift_cnt < base_s + 8 && n < 500) begin @(negedge clk); n++; end
      check("mid_reached_bit7", shift_cnt - base_s, 8);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      reset = 1'b0;
      exp_q.delete();
      repeat (8) @(negedge clk);
      base_s = shift_cnt; base_u = upd_cnt; base_d = done_cnt;
      push_word(16'h3E9C);
      pulse_start();
      wait_done(3000, cyc);
      repeat (3) @(negedge clk);
      check("post_shift_pulses", shift_cnt - base_s, 16);
      check("post_upd_pulses", upd_cnt - base_u, 1);
      check("post_done_pulses", done_cnt - base_d, 1);
      check("post_o_pins", o_pins, 8'hC1);
      check("post_sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
